// File: rtl/uart_rx_deserializer_if.sv
// Receive-byte handshake between the UART deserializer (master) and its consumer (slave).
// framing_error exists only when UART_RX_FRAMING_CHECK_EN is defined.
interface uart_rx_deserializer_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       overrun;
`ifdef UART_RX_FRAMING_CHECK_EN
    logic       framing_error;

    modport master (output data_out, data_out_valid, overrun, framing_error, input data_out_ready);
    modport slave  (input data_out, data_out_valid, overrun, framing_error, output data_out_ready);
`else
    modport master (output data_out, data_out_valid, overrun, input data_out_ready);
    modport slave  (input data_out, data_out_valid, overrun, output data_out_ready);
`endif
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling, one-byte holding register.
// Optional stop-bit check enabled by UART_RX_FRAMING_CHECK_EN (adds framing_error).
module uart_rx_deserializer #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    uart_rx_deserializer_if.master        rx
);
    localparam int SAMPLE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW          = $clog2(SAMPLE_TIME);
    localparam logic [CW-1:0] MID  = CW'(SAMPLE_TIME / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_TIME - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign rx_s = sync[1];

    // Synchronizer resets to 1 so a reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], serial_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            shift             <= '0;
            rx.data_out       <= '0;
            rx.data_out_valid <= 1'b0;
            rx.overrun        <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
            rx.framing_error  <= 1'b0;
`endif
        end else begin
            rx.overrun <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
            rx.framing_error <= 1'b0;
`endif
            if (rx.data_out_ready && rx.data_out_valid)
                rx.data_out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is caught.
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
                        if (!rx_s) begin
                            rx.framing_error <= 1'b1;
                        end else
`endif
                        if (!rx.data_out_valid || rx.data_out_ready) begin
                            rx.data_out       <= shift;
                            rx.data_out_valid <= 1'b1;
                        end else begin
                            rx.overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized scoreboard bench for uart_rx_deserializer (SAMPLE_TIME = 10).
module tb_uart_rx_deserializer;
    localparam int BIT = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic serial_in = 1'b1;
    uart_rx_deserializer_if bus();

    uart_rx_deserializer #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .rx(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    int exp_ovr = 0, ovr_cnt = 0, fe_cnt = 0;
    bit auto_ack = 0;
    int ack_cycle = -1;
    bit lat_arm = 0;
    int lat_start = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Consumer: issues ready either automatically after valid or at a chosen cycle.
    initial begin
        bus.data_out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.data_out_ready = rst_n && ((auto_ack && bus.data_out_valid && !bus.data_out_ready)
                                           || (cyc == ack_cycle));
        end
    end

    // Monitor: pops the scoreboard on every accept and tracks pulses.
    logic       pv = 0, pr = 0;
    logic [7:0] pd = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pr = 0; pd = 0;
            end else begin
                if (bus.data_out_valid && bus.data_out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_byte", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
                    else check("rx_byte", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
                end
                if (pv && !pr && bus.data_out_valid)
                    check("data_stable", {24'd0, bus.data_out}, {24'd0, pd});
                if (lat_arm && bus.data_out_valid && !pv) begin
                    lat_arm = 0;
                    checks++;
                    if (cyc - lat_start < 95 || cyc - lat_start > 100) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles expected 95..100", cyc - lat_start);
                    end
                end
                if (bus.overrun) ovr_cnt++;
`ifdef UART_RX_FRAMING_CHECK_EN
                if (bus.framing_error) fe_cnt++;
`endif
                pv = bus.data_out_valid; pr = bus.data_out_ready; pd = bus.data_out;
            end
        end
    end

    // Caller must be #1 after a posedge; returns #1 after a posedge.
    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        serial_in = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, {24'd0, bus.data_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.data_out_valid}, 32'd0);
        check({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
    endtask

    initial begin
        int o0, vcnt;
        logic [7:0] b;
        idle(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(5);

        // Single byte with latency and one-cycle ready.
        lat_start = cyc; lat_arm = 1;
        send_frame(8'hA5, 1'b1);
        check("a5_valid", {31'd0, bus.data_out_valid}, 32'd1);
        check("a5_data", {24'd0, bus.data_out}, 32'hA5);
        exp_q.push_back(8'hA5);
        ack_cycle = cyc + 1;
        idle(2);
        check("a5_valid_drop", {31'd0, bus.data_out_valid}, 32'd0);
        idle(5);

        // False start then a good frame.
        serial_in = 1'b0; idle(3); serial_in = 1'b1;
        idle(30);
        check("false_start_valid", {31'd0, bus.data_out_valid}, 32'd0);
        auto_ack = 1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(5);

        // Back-to-back frames with no idle gap.
        o0 = ovr_cnt;
        exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFE, 1'b1);
        idle(5);
        check("b2b_overrun", ovr_cnt - o0, 0);

        // Overrun: second byte dropped while first is unread.
        auto_ack = 0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        o0 = ovr_cnt;
        send_frame(8'h22, 1'b1);
        exp_ovr++;
        idle(3);
        check("ovr_data", {24'd0, bus.data_out}, 32'h11);
        check("ovr_valid", {31'd0, bus.data_out_valid}, 32'd1);
        check("ovr_pulses", ovr_cnt - o0, 1);
        auto_ack = 1; idle(4); auto_ack = 0;

        // Ready lands exactly on the delivery cycle of the second byte.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        o0 = ovr_cnt;
        ack_cycle = cyc + 97;
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        check("swap_data", {24'd0, bus.data_out}, 32'h22);
        check("swap_valid", {31'd0, bus.data_out_valid}, 32'd1);
        check("swap_overrun", ovr_cnt - o0, 0);
        auto_ack = 1; idle(4);

`ifdef UART_RX_FRAMING_CHECK_EN
        o0 = fe_cnt;
        send_frame(8'h5A, 1'b0);
        idle(20);
        check("fe_pulses", fe_cnt - o0, 1);
        check("fe_valid", {31'd0, bus.data_out_valid}, 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(5);
`endif

        // Random bytes with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle($urandom_range(0, 15));
        end

        // Asynchronous reset mid-frame with a byte held.
        auto_ack = 0;
        send_frame(8'h77, 1'b1);
        check("pre_reset_valid", {31'd0, bus.data_out_valid}, 32'd1);
        for (int i = 0; i < 25; i++) begin
            serial_in = 1'($urandom); idle(1);
        end
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'($urandom); #3;
        end
        check_outputs_zero("reset_held");
        serial_in = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.data_out_valid) vcnt++;
        end
        check("idle_after_reset", vcnt, 0);
        @(posedge clk); #1;
        auto_ack = 1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) idle(1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("overrun_total", ovr_cnt, exp_ovr);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
